// File: rtl/priv_hazard_unit.sv
// Privileged-instruction decoder (ERET/MTC0/MFC0) with an in-flight MTC0 scoreboard that stalls ID on CP0 RAW hazards.
// Optional feature macro: PRIV_SEL_EN (match on full {rd, sel}; default matches on rd only).
module priv_hazard_unit #(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [31:0]      instrD,
    input  logic             priv_valid,
    input  logic             id_valid,
    input  logic             pipe_adv,
    input  logic             flush,
    output logic             id_is_eret,
    output logic             id_is_mtc0,
    output logic             id_is_mfc0,
    output logic [7:0]       cp0_addr,
    output logic             priv_stall,
    output logic [CNT_W-1:0] pending_cnt
);

`ifdef PRIV_SEL_EN
    localparam int unsigned AW = 8;
`else
    localparam int unsigned AW = 5;
`endif

    logic [4:0]    w_rs;
    logic          w_low_zero;
    logic [AW-1:0] w_key;
    logic          w_match;
    logic          w_any;
    logic          w_issue;
    logic [CNT_W-1:0] w_cnt;

    logic [DEPTH-1:0] r_v;
    logic [AW-1:0]    r_addr [DEPTH];

    // Combinational decode straight off the ID instruction
    assign w_rs       = instrD[25:21];
    assign w_low_zero = (instrD[10:3] == 8'd0);
    assign id_is_eret = (instrD == 32'h4200_0018);
    assign id_is_mtc0 = priv_valid & (w_rs == 5'b00100) & w_low_zero;
    assign id_is_mfc0 = priv_valid & (w_rs == 5'b00000) & w_low_zero;
    assign cp0_addr   = {instrD[15:11], instrD[2:0]};

`ifdef PRIV_SEL_EN
    assign w_key = cp0_addr;
`else
    assign w_key = cp0_addr[7:3];
`endif

    always_comb begin
        w_match = 1'b0;
        w_any   = 1'b0;
        w_cnt   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_match = w_match | (r_v[i] & (r_addr[i] == w_key));
            w_any   = w_any | r_v[i];
            w_cnt   = w_cnt + CNT_W'(r_v[i]);
        end
    end

    // ERET reads EPC/Status, so it waits for every pending write
    assign priv_stall  = id_valid & ((id_is_mfc0 & w_match) | (id_is_eret & w_any));
    assign pending_cnt = w_cnt;
    assign w_issue     = id_valid & id_is_mtc0 & ~priv_stall & pipe_adv & ~flush;

    // Scoreboard shifts with the back end; the oldest entry commits to CP0 as it leaves
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_v <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
            end
        end else if (flush) begin
            r_v <= '0;
        end else if (pipe_adv) begin
            r_v[0]    <= w_issue;
            r_addr[0] <= w_key;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_v[i]    <= r_v[i-1];
                r_addr[i] <= r_addr[i-1];
            end
        end
    end

endmodule

// File: tb/tb_priv_hazard_unit.sv
// Randomized bench for priv_hazard_unit against a list-of-pending-writes reference model.
module tb_priv_hazard_unit;
    localparam int unsigned DEPTH = 3;
    localparam int unsigned CNT_W = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] instrD;
    logic        priv_valid, id_valid, pipe_adv, flush;
    logic        id_is_eret, id_is_mtc0, id_is_mfc0, priv_stall;
    logic [7:0]  cp0_addr;
    logic [CNT_W-1:0] pending_cnt;

    int n_pass = 0;
    int n_total = 0;

    // Model: each pending MTC0 carries its CP0 address and advances left before commit
    logic [7:0] m_addr [$];
    int         m_left [$];
    logic       exp_stall;

    priv_hazard_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .resetn(resetn), .instrD(instrD), .priv_valid(priv_valid),
        .id_valid(id_valid), .pipe_adv(pipe_adv), .flush(flush),
        .id_is_eret(id_is_eret), .id_is_mtc0(id_is_mtc0), .id_is_mfc0(id_is_mfc0),
        .cp0_addr(cp0_addr), .priv_stall(priv_stall), .pending_cnt(pending_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] mk(input int kind, input logic [4:0] rd, input logic [2:0] sel);
        logic [4:0] rt;
        rt = 5'($urandom);
        case (kind)
            0: mk = {6'h10, 5'b00100, rt, rd, 8'h00, sel};
            1: mk = {6'h10, 5'b00000, rt, rd, 8'h00, sel};
            2: mk = 32'h4200_0018;
            3: mk = {6'h10, 5'b00100, rt, rd, 8'h08, sel};
            default: mk = $urandom;
        endcase
    endfunction

    function automatic logic addr_hit(input logic [7:0] a, input logic [7:0] b);
`ifdef PRIV_SEL_EN
        return a == b;
`else
        return a[7:3] == b[7:3];
`endif
    endfunction

    task automatic check_now(input string tag);
        logic e_eret, e_mtc0, e_mfc0, hit;
        logic [7:0] e_addr;
        e_eret = (instrD == 32'h4200_0018);
        e_mtc0 = priv_valid && instrD[25:21] == 5'd4 && instrD[10:3] == 8'd0;
        e_mfc0 = priv_valid && instrD[25:21] == 5'd0 && instrD[10:3] == 8'd0;
        e_addr = {instrD[15:11], instrD[2:0]};
        hit = 1'b0;
        foreach (m_addr[i]) if (addr_hit(m_addr[i], e_addr)) hit = 1'b1;
        exp_stall = id_valid && ((e_mfc0 && hit) || (e_eret && m_addr.size() != 0));
        chk({tag, ".eret"}, 32'(id_is_eret), 32'(e_eret));
        chk({tag, ".mtc0"}, 32'(id_is_mtc0), 32'(e_mtc0));
        chk({tag, ".mfc0"}, 32'(id_is_mfc0), 32'(e_mfc0));
        chk({tag, ".addr"}, 32'(cp0_addr), 32'(e_addr));
        chk({tag, ".stall"}, 32'(priv_stall), 32'(exp_stall));
        chk({tag, ".cnt"}, 32'(pending_cnt), 32'(m_addr.size()));
    endtask

    // One cycle: drive at negedge, check combinational outputs, update model at posedge
    task automatic cyc(input string tag, input logic [31:0] ins, input logic pv,
                       input logic idv, input logic adv, input logic fl);
        logic issue;
        logic [7:0] a;
        @(negedge clk);
        instrD = ins; priv_valid = pv; id_valid = idv; pipe_adv = adv; flush = fl;
        #1;
        check_now(tag);
        issue = idv && pv && ins[25:21] == 5'd4 && ins[10:3] == 8'd0 && !exp_stall && adv && !fl;
        a = {ins[15:11], ins[2:0]};
        @(posedge clk);
        if (fl) begin
            m_addr.delete(); m_left.delete();
        end else if (adv) begin
            for (int i = m_left.size() - 1; i >= 0; i--) begin
                m_left[i] = m_left[i] - 1;
                if (m_left[i] == 0) begin m_left.delete(i); m_addr.delete(i); end
            end
            if (issue) begin m_addr.push_back(a); m_left.push_back(DEPTH); end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        m_addr.delete(); m_left.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        logic [31:0] mfc12;
        resetn = 1'b0; instrD = '0; priv_valid = 0; id_valid = 0; pipe_adv = 0; flush = 0;
        #1;
        chk("reset.cnt", 32'(pending_cnt), 32'd0);
        chk("reset.stall", 32'(priv_stall), 32'd0);
        do_reset();

        // MTC0 $12 then dependent MFC0 $12: stall 1,1,1 then released
        cyc("rawA.mtc0", mk(0, 5'd12, 3'd0), 1, 1, 1, 0);
        mfc12 = mk(1, 5'd12, 3'd0);
        for (int k = 0; k < 4; k++) begin
            cyc("rawA", mfc12, 1, 1, 1, 0);
            chk("rawA.seq", 32'(priv_stall), (k < 3) ? 32'd1 : 32'd0);
        end

        // Same with a 5-cycle back-end hold mid-sequence
        cyc("rawB.mtc0", mk(0, 5'd12, 3'd0), 1, 1, 1, 0);
        cyc("rawB", mfc12, 1, 1, 1, 0);
        for (int k = 0; k < 5; k++) cyc("rawB.hold", mfc12, 1, 1, 0, 0);
        for (int k = 0; k < 3; k++) cyc("rawB.run", mfc12, 1, 1, 1, 0);
        chk("rawB.end", 32'(priv_stall), 32'd0);

        // Different rd / back-to-back MTC0 never stall
        cyc("nodep.mtc0", mk(0, 5'd12, 3'd0), 1, 1, 1, 0);
        cyc("nodep.mfc13", mk(1, 5'd13, 3'd0), 1, 1, 1, 0);
        cyc("waw.a", mk(0, 5'd14, 3'd0), 1, 1, 1, 0);
        cyc("waw.b", mk(0, 5'd15, 3'd0), 1, 1, 1, 0);

        // ERET waits for pending writes; flush releases it
        cyc("eret.mtc0", mk(0, 5'd14, 3'd0), 1, 1, 1, 0);
        cyc("eret.wait", 32'h4200_0018, 1, 1, 1, 0);
        cyc("eret.flush", 32'h4200_0018, 1, 1, 1, 1);
        cyc("eret.after", 32'h4200_0018, 1, 1, 1, 0);
        chk("eret.released", 32'(priv_stall), 32'd0);

        // Same rd, different sel: exact-match build passes, rd-only build stalls
        cyc("sel.mtc0", mk(0, 5'd16, 3'd1), 1, 1, 1, 0);
        for (int k = 0; k < 4; k++) cyc("sel.mfc", mk(1, 5'd16, 3'd0), 1, 1, 1, 0);

        // Asynchronous reset mid-stall with two pending entries
        cyc("rst.m1", mk(0, 5'd12, 3'd0), 1, 1, 1, 0);
        cyc("rst.m2", mk(0, 5'd13, 3'd0), 1, 1, 1, 0);
        cyc("rst.stall", mfc12, 1, 1, 0, 0);
        #2 resetn = 1'b0;
        #1;
        m_addr.delete(); m_left.delete();
        check_now("rst.async");
        chk("rst.cnt0", 32'(pending_cnt), 32'd0);
        @(negedge clk);
        instrD = 32'h4200_0018;
        #1 chk("rst.decode", 32'(id_is_eret), 32'd1);
        @(negedge clk);
        resetn = 1'b1;

        // Randomized traffic on a small register set to provoke hits
        for (int n = 0; n < 600; n++) begin
            int kind, r;
            logic [4:0] rd;
            r = $urandom_range(0, 99);
            kind = (r < 35) ? 0 : (r < 75) ? 1 : (r < 85) ? 2 : (r < 90) ? 3 : 4;
            rd = 5'(12 + $urandom_range(0, 2));
            cyc("rand", mk(kind, rd, 3'($urandom_range(0, 1))),
                $urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0,
                $urandom_range(0, 4) != 0, $urandom_range(0, 29) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
